// File: rtl/fir_op_if.sv
// fir_op_if: operation command channel between the FIR controller (issuer)
// and the FIR datapath (executor).
//   op_valid  issuer -> datapath  command present on op/src1/src2/dest/ext_data
//   op_ready  datapath -> issuer  datapath can accept a command this cycle
//   op        issuer -> datapath  3-bit opcode
//   src1/src2 issuer -> datapath  source register indices
//   dest      issuer -> datapath  destination register index
//   ext_data  issuer -> datapath  external word for the load opcodes
interface fir_op_if #(
    parameter int DATA_W = 16
);
    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        dest;
    logic [DATA_W-1:0] ext_data;

    modport master (
        output op_valid, op, src1, src2, dest, ext_data,
        input  op_ready
    );

    modport slave (
        input  op_valid, op, src1, src2, dest, ext_data,
        output op_ready
    );
endinterface

// File: rtl/fir_datapath.sv
// fir_datapath: execution side of the FIR controller. Holds a 16-entry
// register file and executes one command per accept: NOP, COPY, LOAD_SAMPLE,
// LOAD_COEFF, ADD, SUB complete at the accept edge; MUL runs on a
// sequential shift-add multiplier (DATA_W iterations + 1 writeback cycle)
// and holds op_ready low while it runs.
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   bus       command channel (slave side)
//   overflow  overflow flag of the most recently completed op
//   fir_out   continuous copy of reg[0]
//   busy      multi-cycle op in progress (= ~op_ready)
module fir_datapath #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = DATA_W   // must equal DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    fir_op_if.slave           bus,
    output logic              overflow,
    output logic [DATA_W-1:0] fir_out,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LDS   = 3'b010;
    localparam logic [2:0] OP_LDC   = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   regs [16];
    logic [DATA_W-1:0]   mcand, mplier;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          mul_dest;

    logic [DATA_W-1:0]   rd1, rd2, diff;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] partial;
    logic                accept;

    // Combinational reads see pre-edge contents, so a same-cycle write to the
    // read register is not forwarded (read-before-write).
    assign rd1     = regs[bus.src1];
    assign rd2     = regs[bus.src2];
    assign sum     = {1'b0, rd1} + {1'b0, rd2};
    assign diff    = rd1 - rd2;
    assign partial = {{DATA_W{1'b0}}, mcand} << cnt;

    assign bus.op_ready = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign accept       = bus.op_valid && (state == S_IDLE);
    assign fir_out      = regs[0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && bus.op == OP_MUL) state_nxt = S_MUL;
            S_MUL:   if (cnt == CNT_W'(MUL_CYCLES - 1)) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            overflow <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_dest <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            OP_COPY: begin
                                regs[bus.dest] <= rd1;
                                overflow       <= 1'b0;
                            end
                            OP_LDS, OP_LDC: begin
                                regs[bus.dest] <= bus.ext_data;
                                overflow       <= 1'b0;
                            end
                            OP_ADD: begin
                                regs[bus.dest] <= sum[DATA_W-1:0];
                                overflow       <= sum[DATA_W];
                            end
                            OP_SUB: begin
                                regs[bus.dest] <= diff;
                                overflow       <= (rd1 < rd2);
                            end
                            OP_MUL: begin
                                // Operands are captured here, so dest may alias
                                // a source; overflow is left alone until WB.
                                mcand    <= rd1;
                                mplier   <= rd2;
                                mul_dest <= bus.dest;
                                acc      <= '0;
                                cnt      <= '0;
                            end
                            default: overflow <= 1'b0; // NOP and reserved
                        endcase
                    end
                end
                S_MUL: begin
                    if (mplier[cnt]) acc <= acc + partial;
                    cnt <= cnt + 1'b1;   // wraps to 0 after the last iteration
                end
                S_WB: begin
                    regs[mul_dest] <= acc[DATA_W-1:0];
                    overflow       <= |acc[2*DATA_W-1:DATA_W];
                end
                default: ;
            endcase
        end
    end

    // OP_NOP is covered by the default branch; named here for readability.
    logic unused_nop;
    assign unused_nop = (OP_NOP == 3'b000);
endmodule

// File: doc/fir_datapath.md
Name: fir_datapath

Overview:
- Execution side of the FIR controller's operation interface.
- Holds the 16-entry working register file and executes one op per accepted command: {op, src1, src2, dest}. Op classes: load, copy, add, sub, mul.
- Reports arithmetic overflow back to the controller.
- Drives the filter result continuously from register 0.
- Single-cycle ops complete at the accept edge. MUL runs on a sequential shift-add multiplier, and a valid/ready handshake stalls the issuer while it runs.

Parameters:
- DATA_W, 16, register and operand width (unsigned).
- MUL_CYCLES, DATA_W, number of shift-add iterations. Must equal DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- op_valid  in  1  command present on op/src1/src2/dest/ext_data.
- op_ready  out  1  datapath can accept a command this cycle.
- op  in  3  opcode: 000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEFF, 100 ADD, 101 SUB, 110 MUL, 111 reserved.
- src1  in  4  first source register index.
- src2  in  4  second source register index.
- dest  in  4  destination register index.
- ext_data  in  DATA_W  external word for LOAD_SAMPLE / LOAD_COEFF.
- overflow  out  1  overflow flag of the most recently completed op.
- fir_out  out  DATA_W  continuous copy of reg[0].
- busy  out  1  multi-cycle op in progress (= ~op_ready).

Behaviour:
- Reset (rst=1 at an edge): all 16 registers = 0, state IDLE, op_ready=1, busy=0, overflow=0, fir_out=0. Reset wins over any in-flight op, including mid-MUL; that partial result is discarded.
- Accept rule: a command is accepted at a rising edge where op_valid=1 and op_ready=1. op_valid while op_ready=0 is ignored; the issuer must hold the command.
- State machine: IDLE, MUL, WB. op_ready=1 only in IDLE.
- IDLE, accept of a non-MUL op: result is written to reg[dest] at the accept edge (0-cycle latency after the edge); state stays IDLE. Visible on reg reads and fir_out the next cycle.
  - NOP / 111: no write; overflow <= 0.
  - COPY: reg[dest] <= reg[src1]; overflow <= 0.
  - LOAD_SAMPLE / LOAD_COEFF: reg[dest] <= ext_data; overflow <= 0. The two opcodes are functionally identical in this block.
  - ADD: 17-bit sum src1+src2. reg[dest] <= sum[15:0]; overflow <= sum[16].
  - SUB: reg[dest] <= (src1 - src2) mod 2^16; overflow <= (src1 < src2) (borrow).
- IDLE, accept of MUL:
  - At the accept edge, latch multiplicand = reg[src1], multiplier = reg[src2], dest index; clear the 2*DATA_W accumulator and the iteration counter. Go to MUL.
  - Operands are latched, so dest==src1/src2 is legal.
- MUL: each cycle, if multiplier bit[count]=1, acc += multiplicand << count; count++. After MUL_CYCLES edges (count wraps at DATA_W-1 -> 0) go to WB.
- WB: at the WB edge, reg[dest] <= acc[15:0]; overflow <= |acc[31:16]; go to IDLE.
- MUL latency: the write lands 17 edges after the accept edge (16 MUL + 1 WB). op_ready returns to 1 in the cycle following the WB edge. Throughput is 1 MUL per 18 cycles including the accept cycle.
- overflow holds its value between completions. Every completed op (including NOP) overwrites it. It does not change during MUL/WB until the WB edge.
- Register reads are combinational from the current register contents. A write and a same-cycle read of the same register return the old value (read-before-write).
- Back-to-back single-cycle ops are accepted every cycle; each sees the previous op's result.
- dest may be any index 0..15. A write to reg[0] updates fir_out the next cycle.

Test Plan:
- Reset then LOAD_SAMPLE dest=1 ext_data=0x0005, LOAD_COEFF dest=5 ext_data=0x0003 on consecutive cycles -> reg1=5, reg5=3, overflow=0, op_ready stays 1.
- MUL src1=1 src2=5 dest=10 (5*3) -> op_ready low for exactly 17 cycles after accept; reg10=0x000F at edge 17; overflow=0; op_valid pulses during the busy window are ignored.
- ADD of 0xFFFF + 0x0002 -> dest=0x0001, overflow=1. A following SUB 0x0003 - 0x0005 -> dest=0xFFFE, overflow=1. A following COPY -> overflow=0.
- MUL of 0x0100*0x0100 -> dest=0x0000, overflow=1. MUL of 0xFFFF*0x0001 -> 0xFFFF, overflow=0.
- COPY src1=9 dest=0 with reg9=0x1234 -> fir_out=0x1234 the next cycle.
- Assert rst at cycle 8 of a MUL -> next cycle all regs 0, op_ready=1, overflow=0, and no write to dest occurs afterwards.
